mux_arb_nx1: RTL and testbench
==============================

Name: mux_arb_nx1

Overview:
Parametrised N-to-1 registered multiplexer with per-channel valid/ready handshake. It is the pipelined successor to the team's combinational 2:1 mux. Two operating modes are supported:
- Select-driven: the channel is chosen by an external select, as the CORDIC datapath muxes do.
- Round-robin: the block arbitrates among channels that are presenting valid data.

The output is a single-entry pipeline register. It feeds the CORDIC/FPU datapath stages and back-pressures the sources when the downstream stage stalls.

Parameters:
W, 32, data width per channel
N, 4, number of input channels (2..16)
SW, 2, select/grant index width; must satisfy 2^SW >= N
MODE, 0, 0 = select-driven, 1 = round-robin arbitration

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
select  input  SW  channel index; used only when MODE=0
ch_data  input  N*W  packed channel data; channel i occupies bits [i*W+W-1 : i*W]
ch_valid  input  N  channel i has data
ch_ready  output  N  channel i is accepted this cycle
data_out  output  W  registered selected data
sel_out  output  SW  index of the channel held in data_out
valid_out  output  1  data_out valid
ready_in  input  1  downstream accepts data_out

Behaviour:
Reset:
- Asynchronous on rst=0.
- data_out=0, sel_out=0, valid_out=0, round-robin pointer=N-1.
- ch_ready is combinational; it is all-zero while rst=0.
- Reset asserted mid-transfer discards the held word; no partial state survives.

Load enable:
- load_en = !valid_out || ready_in.
- The output register accepts a new word whenever it is empty or being drained in the same cycle. This gives full throughput of 1 word/cycle.

Grant, MODE=0:
- grant = select, only if select < N and ch_valid[select]=1.
- If select >= N, there is no grant.
- Valid signals of other channels are ignored.

Grant, MODE=1:
- Search channels ptr+1, ptr+2, ... modulo N; the first channel with ch_valid=1 wins.
- ptr updates to the granted index only on an actual transfer, i.e. when a grant occurs and load_en=1.
- ptr wraps from N-1 to 0.

Handshake:
- ch_ready[i] = load_en && (grant == i) && grant exists. At most one ch_ready bit is high per cycle (one-hot or zero).
- Transfer on channel i: ch_valid[i] && ch_ready[i].
- On the next rising edge: data_out <= ch_data slice i, sel_out <= i, valid_out <= 1.

Output updates:
- load_en=1 with no grant: valid_out <= 0; data_out and sel_out hold their last values.
- valid_out=1 and ready_in=0: data_out, sel_out and valid_out hold stable. All ch_ready=0.

Latency:
- 1 cycle from an input transfer to valid_out.
- Simultaneous drain and load in the same cycle is legal; the new word replaces the old with no bubble.

Boundary conditions:
- ch_valid may drop without a transfer; no requirement is placed on the source.
- A select change while stalled has no effect until load_en=1.
- N not a power of two: unused select codes are never granted.

Widths:
- No arithmetic on data.
- The pointer increment is modulo N, implemented as compare-and-wrap, not as SW-bit overflow.

Test Plan:
- Reset: rst=0 during traffic -> data_out=0, valid_out=0, sel_out=0, ch_ready=0 immediately (async); after release, the first round-robin grant goes to channel 0.
- MODE=0, N=4, W=32, ready_in=1: select=2, ch_valid=4'b0100, ch_data[2]=32'hDEADBEEF -> ch_ready=4'b0100; next cycle data_out=32'hDEADBEEF, sel_out=2, valid_out=1.
- MODE=0 invalid select: N=3, SW=2, select=3, all ch_valid=1 -> ch_ready=0; valid_out falls to 0 after the next edge.
- MODE=1 fairness: ch_valid=4'b1111 held, ready_in=1 -> sel_out sequence 0,1,2,3,0 on consecutive cycles, valid_out continuously 1.
- Back-pressure: valid_out=1 holding 32'h12345678, ready_in=0 for 3 cycles with other channels valid -> data_out stable, ch_ready=0; on ready_in=1, a same-cycle reload occurs with no bubble.
- MODE=1 sparse request: ptr=1, ch_valid=4'b0001 -> grant wraps to channel 0, ptr becomes 0; next grant with ch_valid=4'b0011 goes to channel 1.

Source files
------------

// File: rtl/mux_arb_nx1.sv
// N-to-1 registered multiplexer with per-channel valid/ready handshake.
// Channel choice comes from an external select (MODE=0) or a round-robin arbiter (MODE=1).
module mux_arb_nx1 #(
    parameter int W    = 32,
    parameter int N    = 4,
    parameter int SW   = 2,
    parameter int MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW-1:0]   select,
    input  logic [N*W-1:0]  ch_data,
    input  logic [N-1:0]    ch_valid,
    output logic [N-1:0]    ch_ready,
    output logic [W-1:0]    data_out,
    output logic [SW-1:0]   sel_out,
    output logic            valid_out,
    input  logic            ready_in
);

    localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

    logic [W-1:0]  data_q,  data_d;
    logic [SW-1:0] sel_q,   sel_d;
    logic          valid_q, valid_d;
    logic [SW-1:0] ptr_q,   ptr_d;

    logic          load_en;
    logic          grant_vld;
    logic [SW-1:0] grant_idx;
    logic [SW-1:0] cand;
    logic [W-1:0]  grant_data;

    // The register takes a word whenever it is empty or is being drained this cycle.
    assign load_en = !valid_q || ready_in;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = ptr_q;
        if (MODE == 0) begin
            // Codes >= N match no channel, so they are never granted.
            for (int i = 0; i < N; i++) begin
                if (select == SW'(i) && ch_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end else begin
            // Visit ptr+1, ptr+2, ... with an explicit wrap at N-1; first requester wins.
            for (int k = 0; k < N; k++) begin
                cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (!grant_vld && cand == SW'(i) && ch_valid[i]) begin
                        grant_vld = 1'b1;
                        grant_idx = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SW'(i)) begin
                grant_data = ch_data[i*W +: W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ch_ready[i] = rst && load_en && grant_vld && (grant_idx == SW'(i));
        end
    end

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            // With no grant the slot empties but the last word and index stay visible.
            valid_d = grant_vld;
            if (grant_vld) begin
                data_d = grant_data;
                sel_d  = grant_idx;
                if (MODE == 1) begin
                    ptr_d = grant_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= LAST_IDX;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign data_out  = data_q;
    assign sel_out   = sel_q;
    assign valid_out = valid_q;

    ready_onehot_a: assert property (@(posedge clk) disable iff (!rst) $onehot0(ch_ready));
    ready_needs_valid_a: assert property (@(posedge clk) disable iff (!rst) (ch_ready & ~ch_valid) == '0);
    ptr_range_a: assert property (@(posedge clk) disable iff (!rst) ptr_q <= LAST_IDX);
    stall_hold_a: assert property (@(posedge clk) disable iff (!rst)
        (valid_out && !ready_in) |=> (valid_out && $stable(data_out) && $stable(sel_out)));

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Bench for mux_arb_nx1: a select-driven N=3 instance and a round-robin N=4 instance,
// both checked at every falling edge against a queue-based reference model.
module tb_mux_arb_nx1;

    localparam int W  = 32;
    localparam int SW = 2;
    localparam int N0 = 3;
    localparam int N1 = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // instance 0: MODE=0, N=3
    logic [SW-1:0]   s0_select;
    logic [N0*W-1:0] s0_data;
    logic [N0-1:0]   s0_valid;
    logic [N0-1:0]   s0_ready;
    logic [W-1:0]    s0_dout;
    logic [SW-1:0]   s0_sel;
    logic            s0_vout;
    logic            s0_rin;

    // instance 1: MODE=1, N=4
    logic [SW-1:0]   r1_select;
    logic [N1*W-1:0] r1_data;
    logic [N1-1:0]   r1_valid;
    logic [N1-1:0]   r1_ready;
    logic [W-1:0]    r1_dout;
    logic [SW-1:0]   r1_sel;
    logic            r1_vout;
    logic            r1_rin;

    mux_arb_nx1 #(.W(W), .N(N0), .SW(SW), .MODE(0)) u_sel (
        .clk(clk), .rst(rst), .select(s0_select), .ch_data(s0_data),
        .ch_valid(s0_valid), .ch_ready(s0_ready), .data_out(s0_dout),
        .sel_out(s0_sel), .valid_out(s0_vout), .ready_in(s0_rin)
    );

    mux_arb_nx1 #(.W(W), .N(N1), .SW(SW), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .select(r1_select), .ch_data(r1_data),
        .ch_valid(r1_valid), .ch_ready(r1_ready), .data_out(r1_dout),
        .sel_out(r1_sel), .valid_out(r1_vout), .ready_in(r1_rin)
    );

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    logic [SW+W-1:0] exp_q0[$];
    logic [SW+W-1:0] exp_q1[$];

    // Reference state: is the output slot full, last word shown, last granted channel.
    bit              m_full[2];
    int              m_ptr[2];
    logic [SW+W-1:0] m_last[2];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int model_grant(int mode, int n, int ptr, int sel, logic [15:0] vld);
        if (mode == 0) begin
            if (sel < n && vld[sel]) return sel;
            return -1;
        end
        for (int k = 1; k <= n; k++) begin
            int c;
            c = (ptr + k) % n;
            if (vld[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_reset(int id, int n);
        m_full[id] = 1'b0;
        m_ptr[id]  = n - 1;
        m_last[id] = '0;
        if (id == 0) exp_q0.delete();
        else         exp_q1.delete();
    endfunction

    function automatic void model_step(int id, int mode, int n, int sel, logic [15:0] vld,
                                       logic [4*W-1:0] data, logic rin, logic [15:0] act_ready,
                                       logic act_vout, logic [SW-1:0] act_sel, logic [W-1:0] act_dout);
        int              g;
        bit              load;
        logic [15:0]     exp_ready;
        logic [SW+W-1:0] word;
        string           tag;
        tag = (id == 0) ? "sel" : "rr";

        chk({tag, " valid_out"}, 64'(act_vout), 64'(m_full[id]));
        chk({tag, " held word"}, 64'({act_sel, act_dout}), 64'(m_last[id]));

        load      = !m_full[id] || rin;
        g         = model_grant(mode, n, m_ptr[id], sel, vld);
        exp_ready = (load && g >= 0) ? (16'd1 << g) : 16'd0;
        chk({tag, " ch_ready"}, 64'(act_ready), 64'(exp_ready));

        if (act_vout && rin) begin
            if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL %s drained word: got %0h expected none queued", tag, {act_sel, act_dout});
            end else begin
                word = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk({tag, " drained word"}, 64'({act_sel, act_dout}), 64'(word));
            end
        end

        if (load) begin
            if (g >= 0) begin
                word = {SW'(g), data[g*W +: W]};
                if (id == 0) exp_q0.push_back(word);
                else         exp_q1.push_back(word);
                m_full[id] = 1'b1;
                m_last[id] = word;
                if (mode == 1) m_ptr[id] = g;
            end else begin
                m_full[id] = 1'b0;
            end
        end
    endfunction

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk or negedge rst);
            if (!rst) begin
                #1;
                chk("sel reset outputs", 64'({s0_vout, s0_sel, s0_dout}), 64'd0);
                chk("sel reset ch_ready", 64'(s0_ready), 64'd0);
                chk("rr reset outputs", 64'({r1_vout, r1_sel, r1_dout}), 64'd0);
                chk("rr reset ch_ready", 64'(r1_ready), 64'd0);
                model_reset(0, N0);
                model_reset(1, N1);
            end else if (done) begin
                chk("sel queue drained", 64'(exp_q0.size()), 64'd0);
                chk("rr queue drained", 64'(exp_q1.size()), 64'd0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end else begin
                model_step(0, 0, N0, int'(s0_select), 16'(s0_valid), (4*W)'(s0_data), s0_rin,
                           16'(s0_ready), s0_vout, s0_sel, s0_dout);
                model_step(1, 1, N1, int'(r1_select), 16'(r1_valid), (4*W)'(r1_data), r1_rin,
                           16'(r1_ready), r1_vout, r1_sel, r1_dout);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N0; i++) s0_data[i*W +: W] = $urandom;
        for (int i = 0; i < N1; i++) r1_data[i*W +: W] = $urandom;
    endtask

    // Driver
    initial begin
        s0_select = '0; s0_data = '0; s0_valid = '0; s0_rin = 1'b0;
        r1_select = '0; r1_data = '0; r1_valid = '0; r1_rin = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // select-driven: grant channel 2, then an out-of-range select
        s0_rin = 1'b1; r1_rin = 1'b1;
        s0_select = 2'd2; s0_valid = 3'b100;
        s0_data[2*W +: W] = 32'hDEADBEEF;
        step();
        s0_select = 2'd3; s0_valid = 3'b111;
        step();
        step();
        s0_valid = '0;

        // round-robin fairness with all channels requesting
        r1_valid = 4'b1111;
        repeat (5) begin
            rand_data();
            step();
        end

        // back-pressure: hold a word for three cycles, then reload with no bubble
        r1_data[1*W +: W] = 32'h12345678;
        step();
        r1_rin = 1'b0;
        repeat (3) begin
            rand_data();
            s0_select = 2'($urandom_range(0, 3));
            step();
        end
        r1_rin = 1'b1;
        step();
        r1_valid = '0;
        step();

        // sparse requests: wrap from channel 1 to 0, then on to 1
        r1_valid = 4'b0010; step();
        r1_valid = 4'b0001; step();
        r1_valid = 4'b0011; step();
        r1_valid = '0;      step();

        // randomized traffic with one asynchronous reset mid-stream
        for (int c = 0; c < 400; c++) begin
            rand_data();
            s0_select = 2'($urandom_range(0, 3));
            s0_valid  = 3'($urandom);
            r1_valid  = 4'($urandom);
            s0_rin    = ($urandom_range(0, 3) != 0);
            r1_rin    = ($urandom_range(0, 3) != 0);
            if (c == 200) begin
                #2 rst = 1'b0;
                step();
                rst = 1'b1;
            end
            step();
        end

        s0_valid = '0; r1_valid = '0;
        s0_rin = 1'b1; r1_rin = 1'b1;
        repeat (4) step();
        done = 1'b1;
        repeat (10) step();
        $display("FAIL monitor timeout: got no summary expected summary within 10 cycles");
        $fatal(1);
    end

endmodule
